uart_tx_pkt_arbiter: RTL
========================

# uart_tx_pkt_arbiter

- Shares the single byte-level UART transmitter (`tx_data`/`tx_start`/`tx_busy` interface) between several packet sources in the gatekeeper design: challenge sender, AUTH_OK/AUTH_FAIL responder, status reporter.
- Round-robin grants one requester at a time and latches its packet (command byte plus 0–4 payload bytes).
- Issues the bytes to the transmitter back-to-back, then acknowledges completion or a transmitter fault to the requester.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..4).
- `MAX_PAYLOAD`, default 4: maximum payload bytes per packet.
- `BUSY_TIMEOUT`, default 8: cycles allowed for `tx_busy` to rise after `tx_start`.
- `CLK` in 1: 12 MHz system clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a packet pending.
- `req_cmd` in 8*NUM_REQ: command byte, slice i.
- `req_payload` in 8*MAX_PAYLOAD*NUM_REQ: payload, slice i.
- `req_len` in 3*NUM_REQ: payload byte count, slice i.
- `req_done` out NUM_REQ: one-cycle pulse; packet fully transmitted.
- `req_err` out NUM_REQ: one-cycle pulse; packet aborted on timeout.
- `tx_data` out 8: byte to the transmitter.
- `tx_start` out 1: one-cycle start strobe.
- `tx_busy` in 1: transmitter busy.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out 2: index of the current or last granted requester.

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, DONE.
- **IDLE**
  - If any `req_valid` is high, pick the first requester found searching cyclically from `grant_id+1`, then go to LOAD.
- **LOAD**
  - Latch cmd, payload and len of the winner into internal registers; set `grant_id`.
  - len > MAX_PAYLOAD clamps to MAX_PAYLOAD.
  - Byte counter = 0; go to ISSUE.
  - Requester inputs are not sampled again for this packet. Dropping `req_valid` mid-packet does not abort it.
- **ISSUE**
  - Drive `tx_data` with byte k and pulse `tx_start`; go to WAIT_HI.
  - Byte 0 = cmd. Bytes 1..len = payload[8*len-1:0], most-significant byte first.
- **WAIT_HI**
  - `tx_busy` high → WAIT_LO.
  - If `tx_busy` has not risen BUSY_TIMEOUT cycles after the strobe: pulse `req_err[grant_id]` and return to IDLE. No further bytes are sent.
- **WAIT_LO**
  - On `tx_busy` low: if k == len, go to DONE; otherwise k+1 and go to ISSUE.
- **DONE**
  - Pulse `req_done[grant_id]`; go to IDLE.
- The requester deasserts `req_valid` in the cycle after `req_done`/`req_err`. A requester still asserting then is treated as a new packet and wins only in its round-robin turn.
- Byte counter and timeout counter are 3 and 4 bits wide. No arithmetic wraps within legal ranges.
- Reset values:
  - `tx_start`, `req_done`, `req_err`, `busy`, `tx_data` = 0.
  - `grant_id` = NUM_REQ-1, so requester 0 wins the first arbitration.
  - FSM = IDLE.
- `RST` mid-packet: next cycle all outputs are at reset values and the packet is dropped silently (no done, no err).

## Timing
- `req_valid` sampled high in IDLE at cycle t:
  - LOAD at t+1.
  - `tx_start` with cmd at t+2.
- `tx_start` is never asserted while `tx_busy` is high, and never on two consecutive cycles.
- Next byte's `tx_start` comes exactly 1 cycle after `tx_busy` is sampled low in WAIT_LO.
- `req_done` comes 1 cycle after the final `tx_busy` fall.
- Packet overhead beyond UART time is 3 cycles per byte plus 2 cycles of arbitration.
- `tx_data` is stable from the `tx_start` cycle until the next ISSUE.
- Simultaneous requests are resolved only by the round-robin pointer. There is no fixed priority.

## Structure
- Shared package `gatekeeper_pkg` holds:
  - Command codes: PROG_REQUEST=0x01, CHALLENGE=0x02, RESPONSE=0x03, AUTH_OK=0x04, AUTH_FAIL=0x05, STATUS=0x06.
  - FSM state encodings.
  - Default MAX_PAYLOAD.
- One sub-module, `rr_pick`: combinational round-robin selector taking `req_valid` and last grant, returning winner index and a valid flag.
- Payload shifting and the FSM stay in the top module.

## Test plan
- Req0 with cmd 0x02, payload 0xA1B2C3D4, len 4 → tx bytes 02,A1,B2,C3,D4 in order; one `req_done[0]` pulse; `busy` low afterwards.
- Req0 (cmd 0x04) and req2 (cmd 0x05), both len 0, asserted together after reset → 04 then 05.
- All three requesters held valid for four packets → grant order 0,1,2,0.
- Req1 with len 2, payload 0x0000BEEF → 06,BE,EF. With len 7, payload 0x11223344 → 06,11,22,33,44 (clamped).
- Model holds `tx_busy` low → `req_err[grant_id]` pulses 8 cycles after the strobe; no further `tx_start`; next requester is then served normally.
- `RST` asserted during payload byte 2 → `tx_start`, `busy` and `grant_id` at reset values next cycle; no `req_done`; a fresh req0 afterwards transmits fully.

Source files
------------

// File: rtl/gatekeeper_pkg.sv
// Shared definitions for the gatekeeper UART path: command codes, arbiter
// state encoding and the payload length clamp.
package gatekeeper_pkg;

  localparam logic [7:0] PROG_REQUEST = 8'h01;
  localparam logic [7:0] CHALLENGE    = 8'h02;
  localparam logic [7:0] RESPONSE     = 8'h03;
  localparam logic [7:0] AUTH_OK      = 8'h04;
  localparam logic [7:0] AUTH_FAIL    = 8'h05;
  localparam logic [7:0] STATUS       = 8'h06;

  localparam int DEFAULT_MAX_PAYLOAD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } arb_state_t;

  function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_len);
    return (int'(len) > max_len) ? 3'(max_len) : len;
  endfunction

endpackage

// File: rtl/uart_tx_pkt_arbiter_rr_pick.sv
// Round-robin selector: first valid requester searching cyclically from
// the slot after the last grant.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         last_id,
  output logic [1:0]         win_id,
  output logic               win_valid
);

  always_comb begin
    logic [1:0] cand;
    cand      = last_id;
    win_id    = last_id;
    win_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = 2'((int'(last_id) + i) % NUM_REQ);
      if (!win_valid && req_valid[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_pkt_arbiter.sv
// Shares one byte-level UART transmitter between several packet sources;
// a packet is a command byte followed by 0..MAX_PAYLOAD payload bytes.
//
// state   | meaning
// IDLE    | waiting for any req_valid; winner chosen round-robin
// LOAD    | latch winner's cmd/payload/len, first byte staged on tx_data
// ISSUE   | tx_start strobe for the staged byte
// WAIT_HI | waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_LO | waiting for tx_busy to fall, then next byte or DONE
// DONE    | req_done pulse to the granted requester
module uart_tx_pkt_arbiter
  import gatekeeper_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int MAX_PAYLOAD  = DEFAULT_MAX_PAYLOAD,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [8*NUM_REQ-1:0]              req_cmd,
  input  logic [8*MAX_PAYLOAD*NUM_REQ-1:0]  req_payload,
  input  logic [3*NUM_REQ-1:0]              req_len,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [NUM_REQ-1:0]                req_err,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic                              busy,
  output logic [1:0]                        grant_id
);

  localparam int PW = 8 * MAX_PAYLOAD;

  arb_state_t    state_q, state_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    len_q, len_d;
  logic [3:0]    tmo_q, tmo_d;
  logic [PW-1:0] pl_q, pl_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic [1:0]    pick_id;
  logic          pick_valid;
  logic [7:0]    cmd_arr [NUM_REQ];
  logic [PW-1:0] pl_arr  [NUM_REQ];
  logic [2:0]    len_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_arr[i] = req_cmd[8*i +: 8];
      pl_arr[i]  = req_payload[PW*i +: PW];
      len_arr[i] = clamp_len(req_len[3*i +: 3], MAX_PAYLOAD);
    end
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .last_id   (grant_id_q),
    .win_id    (pick_id),
    .win_valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    pl_d       = pl_q;
    tx_data_d  = tx_data_q;
    tx_start   = 1'b0;
    req_done   = '0;
    req_err    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // Left-align the used payload bytes so each byte is taken from the top.
        len_d     = len_arr[grant_id_q];
        pl_d      = pl_arr[grant_id_q] << (8 * (MAX_PAYLOAD - int'(len_arr[grant_id_q])));
        tx_data_d = cmd_arr[grant_id_q];
        cnt_d     = '0;
        state_d   = ISSUE;
      end
      ISSUE: begin
        tx_start = 1'b1;
        tmo_d    = 4'(BUSY_TIMEOUT - 1);
        state_d  = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == 4'd0) begin
          req_err[grant_id_q] = 1'b1;
          state_d             = IDLE;
        end else begin
          tmo_d = tmo_q - 4'd1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            cnt_d     = cnt_q + 3'd1;
            tx_data_d = pl_q[PW-1 -: 8];
            pl_d      = pl_q << 8;
            state_d   = ISSUE;
          end
        end
      end
      DONE: begin
        req_done[grant_id_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      grant_id_q <= 2'(NUM_REQ - 1);
      cnt_q      <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      pl_q       <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      pl_q       <= pl_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

endmodule
